// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Conditions raw board pins for the CPU core's gpi port. Each bit is
//   synchronised into clk, debounced against a shared sample tick and
//   presented as a clean registered level. The block also emits one-cycle
//   rise/fall pulses for downstream event logic.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   pin_in   raw asynchronous pin levels
//   gpi      debounced registered level
//   rise     one-cycle pulse per bit on an accepted 0->1
//   fall     one-cycle pulse per bit on an accepted 1->0
//   changed  OR of all rise/fall pulses
module gpio_in_conditioner #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned TICK_DIV     = 1000,
   parameter int unsigned STABLE_TICKS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] gpi,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
   localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [PreW-1:0]  presc_q, presc_d;
   logic             tick;
   logic [CntW-1:0]  cnt_q [WIDTH];
   logic [CntW-1:0]  cnt_d [WIDTH];
   logic [WIDTH-1:0] gpi_q, gpi_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;

   // Shared prescaler: tick is high for the last cycle of every period.
   assign tick    = (presc_q == PreLast);
   assign presc_d = tick ? '0 : presc_q + PreW'(1);

   // Per-bit debounce: count consecutive tick samples that disagree with
   // the current level; any agreeing sample restarts the count.
   always_comb begin
      gpi_d  = gpi_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (sync2_q[i] == gpi_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
               cnt_d[i]  = '0;
               gpi_d[i]  = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         cnt_q   <= '{default: '0};
         gpi_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         gpi_q   <= gpi_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign gpi     = gpi_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign changed = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner. Two instances share the same stimulus:
// u_dut0 (TICK_DIV=4, STABLE_TICKS=3) and u_dut1 (TICK_DIV=1, STABLE_TICKS=1).
// The reference model keeps the full pin history and the list of tick
// samples, and accepts a new level when the last STABLE_TICKS samples taken
// since the previous acceptance all disagree with the current level.
module tb_gpio_in_conditioner;

   localparam int W    = 8;
   localparam int NI   = 2;
   localparam int HMAX = 8192;

   int td [NI] = '{4, 1};
   int st [NI] = '{3, 1};

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] pin_in;
   logic [W-1:0] gpi0, rise0, fall0, gpi1, rise1, fall1;
   logic         changed0, changed1;

   int checks = 0;
   int errors = 0;

   // Model state
   int           cyc;
   logic [W-1:0] phist [HMAX];
   logic [W-1:0] samp [NI][HMAX];
   int           nsamp [NI];
   int           last_acc [NI][W];
   logic [W-1:0] m_gpi [NI];
   logic [W-1:0] m_rise [NI];
   logic [W-1:0] m_fall [NI];

   always #5 clk = ~clk;

   gpio_in_conditioner #(
      .WIDTH       (W),
      .TICK_DIV    (4),
      .STABLE_TICKS(3)
   ) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .pin_in (pin_in),
      .gpi    (gpi0),
      .rise   (rise0),
      .fall   (fall0),
      .changed(changed0)
   );

   gpio_in_conditioner #(
      .WIDTH       (W),
      .TICK_DIV    (1),
      .STABLE_TICKS(1)
   ) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .pin_in (pin_in),
      .gpi    (gpi1),
      .rise   (rise1),
      .fall   (fall1),
      .changed(changed1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one clk edge with inputs (r, p).
   task automatic model_edge(input logic r, input logic [W-1:0] p);
      logic [W-1:0] s2;
      logic         ok;
      int           n;
      if (r) begin
         cyc = 0;
         for (int k = 0; k < NI; k++) begin
            nsamp[k]  = 0;
            m_gpi[k]  = '0;
            m_rise[k] = '0;
            m_fall[k] = '0;
            for (int b = 0; b < W; b++) last_acc[k][b] = 0;
         end
      end else begin
         // Level seen by the debouncer: pin two cycles ago, zero right after reset.
         s2 = (cyc >= 2) ? phist[cyc-2] : '0;
         for (int k = 0; k < NI; k++) begin
            m_rise[k] = '0;
            m_fall[k] = '0;
            if ((cyc % td[k]) == td[k] - 1) begin
               samp[k][nsamp[k]] = s2;
               nsamp[k]++;
               n = nsamp[k];
               for (int b = 0; b < W; b++) begin
                  if (n - last_acc[k][b] >= st[k]) begin
                     ok = 1'b1;
                     for (int j = n - st[k]; j < n; j++)
                        if (samp[k][j][b] == m_gpi[k][b]) ok = 1'b0;
                     if (ok) begin
                        m_gpi[k][b]    = ~m_gpi[k][b];
                        m_rise[k][b]   = m_gpi[k][b];
                        m_fall[k][b]   = ~m_gpi[k][b];
                        last_acc[k][b] = n;
                     end
                  end
               end
            end
         end
         phist[cyc] = p;
         cyc++;
      end
   endtask

   task automatic compare_all();
      check("gpi0", 32'(gpi0), 32'(m_gpi[0]));
      check("rise0", 32'(rise0), 32'(m_rise[0]));
      check("fall0", 32'(fall0), 32'(m_fall[0]));
      check("changed0", 32'(changed0), 32'(|(m_rise[0] | m_fall[0])));
      check("excl0", 32'(rise0 & fall0), 32'd0);
      check("gpi1", 32'(gpi1), 32'(m_gpi[1]));
      check("rise1", 32'(rise1), 32'(m_rise[1]));
      check("fall1", 32'(fall1), 32'(m_fall[1]));
      check("changed1", 32'(changed1), 32'(|(m_rise[1] | m_fall[1])));
   endtask

   // One clock cycle: drive, compare mid-cycle, then cross the edge.
   task automatic step(input logic r, input logic [W-1:0] p);
      rst    = r;
      pin_in = p;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge(r, p);
      #1;
   endtask

   task automatic hold(input logic [W-1:0] p, input int n);
      for (int i = 0; i < n; i++) step(1'b0, p);
   endtask

   initial begin
      logic [W-1:0] v;
      int           len;
      rst    = 1'b1;
      pin_in = '0;
      model_edge(1'b1, '0);
      @(posedge clk);
      #1;

      // Reset with quiet pins
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00);

      // Release with bit 0 high; explicit latency checks on both instances
      for (int c = 0; c < 16; c++) begin
         step(1'b0, 8'h01);
         check("lat_gpi0", 32'(gpi0), (c + 1 >= 12) ? 32'h01 : 32'h00);
         check("lat_rise0", 32'(rise0), (c + 1 == 12) ? 32'h01 : 32'h00);
         check("lat_gpi1", 32'(gpi1), (c + 1 >= 3) ? 32'h01 : 32'h00);
         check("lat_rise1", 32'(rise1), (c + 1 == 3) ? 32'h01 : 32'h00);
      end

      // Bounce: two differing ticks, one agreeing tick, then steady low
      hold(8'h00, 8);
      hold(8'h01, 4);
      hold(8'h00, 24);

      // Short glitch on bit 3 that no tick samples (instance 0)
      while ((cyc % 4) != 2) step(1'b0, 8'h00);
      hold(8'h08, 2);
      hold(8'h00, 12);

      // Multi-bit simultaneous updates
      hold(8'hA5, 20);
      hold(8'h5A, 20);
      hold(8'h00, 20);

      // Reset in the middle of a bit-7 debounce, pin held through it
      while ((cyc % 4) != 0) step(1'b0, 8'h00);
      hold(8'h80, 10);
      step(1'b1, 8'h80);
      step(1'b1, 8'h80);
      hold(8'h80, 20);

      // Randomised levels with occasional glitches and resets
      v = 8'h00;
      for (int blk = 0; blk < 200; blk++) begin
         v   = 8'($urandom);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 299) == 0) step(1'b1, v);
            else if ($urandom_range(0, 9) == 0) step(1'b0, v ^ 8'($urandom));
            else step(1'b0, v);
         end
      end
      hold(8'h00, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
